// File: rtl/pixel_stream_feeder_pkg.sv
// Shared definitions for pixel_stream_feeder: FSM state encoding, command word
// field positions and the default frame size.
package pixel_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    CLEAR
  } state_t;

  localparam int CMD_CLEAR_BIT = 15;
  localparam int REP_MSB       = 14;
  localparam int REP_LSB       = 12;
  localparam int RGB_MSB       = 11;

  localparam int NPIX_DEFAULT  = 1200;

endpackage

// File: rtl/pixel_stream_feeder_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy level.
// Pushes while full and pops while empty are ignored.
module sync_fifo
  import pixel_feeder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk_50,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (do_push && !do_pop) begin
      level_next = level + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      level_next = level - (AW+1)'(1);
    end
  end

  // Storage is not reset; only the pointers and flags define what is valid.
  always_ff @(posedge clk_50) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      full  <= (level_next == (AW+1)'(DEPTH));
      empty <= (level_next == '0);
    end
  end

endmodule

// File: rtl/pixel_stream_feeder.sv
// Buffers CPU pixel/command words and replays them as a pulsed pixel stream.
// Optional run-length repeat support is enabled by defining PIXEL_FEEDER_RLE_EN.
module pixel_stream_feeder
  import pixel_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int HOLD  = 1,
  parameter int GAP   = 1,
  parameter int NPIX  = NPIX_DEFAULT
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  output logic        add_input,
  output logic [11:0] rgb_code,
  output logic        img_reset,
  output logic [10:0] pix_idx,
  output logic        frame_done,
  output logic        busy
);

  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int MAXHG = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW    = $clog2(MAXHG) + 1;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP - 1);
  localparam logic [10:0]   LAST_IDX  = 11'(NPIX - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [15:0]     head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [LW-1:0]   fifo_level;
  logic            pop;
  logic            at_last;

`ifdef PIXEL_FEEDER_RLE_EN
  logic [2:0]      rep;
`else
  logic            unused_rep;
  assign unused_rep = ^head[REP_MSB:REP_LSB];
`endif

  assign pop      = (state == IDLE) && !fifo_empty;
  assign wr_ready = !fifo_full;
  assign busy     = (fifo_level != '0) || (state != IDLE);
  assign at_last  = (pix_idx == LAST_IDX);

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_50 (clk_50),
    .reset  (reset),
    .push   (wr_valid),
    .din    (wr_data),
    .pop    (pop),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // frame_done is loaded one cycle early so it is high during the last LO cycle,
  // the same cycle in which pix_idx wraps.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      add_input  <= 1'b0;
      rgb_code   <= '0;
      img_reset  <= 1'b0;
      pix_idx    <= '0;
      frame_done <= 1'b0;
`ifdef PIXEL_FEEDER_RLE_EN
      rep        <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      img_reset  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (head[CMD_CLEAR_BIT]) begin
              img_reset <= 1'b1;
              state     <= CLEAR;
            end else begin
              rgb_code  <= head[RGB_MSB:0];
`ifdef PIXEL_FEEDER_RLE_EN
              rep       <= head[REP_MSB:REP_LSB];
`endif
              add_input <= 1'b1;
              cnt       <= HOLD_LOAD;
              state     <= HI;
            end
          end
        end
        HI: begin
          if (cnt == '0) begin
            add_input  <= 1'b0;
            cnt        <= GAP_LOAD;
            frame_done <= (GAP == 1) && at_last;
            state      <= LO;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        LO: begin
          if (cnt == '0) begin
            pix_idx <= at_last ? 11'd0 : pix_idx + 11'd1;
`ifdef PIXEL_FEEDER_RLE_EN
            if (rep != 3'd0) begin
              rep       <= rep - 3'd1;
              add_input <= 1'b1;
              cnt       <= HOLD_LOAD;
              state     <= HI;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end else begin
            cnt        <= cnt - CW'(1);
            frame_done <= (cnt == CW'(1)) && at_last;
          end
        end
        CLEAR: begin
          pix_idx <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
